regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the register file's single write port and shares it between two requesters:
//   - req0: the in-order pipeline writeback.
//   - req1: the long-latency unit (mul/div/load return).
//  Tracks outstanding long-latency writes per register so decode can stall on RAW hazards.
//  Drives the register file write port directly and combinationally; the register file
//  already bypasses same-cycle writes to its read ports.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive stalled cycles of req1 before req1 is forced to win; legal range 1..15
//  CNT_W         2  width of each per-register pending-write counter (max 2**CNT_W-1 in flight per reg)
// PORTS
//  clk           in   1    single clock; all state updates on posedge
//  rst           in   1    asynchronous, active-high reset
//  wb0_valid     in   1    pipeline writeback request
//  wb0_id        in   5    reg_id_t destination
//  wb0_data      in   32   op_t value
//  wb0_ready     out  1    req0 accepted this cycle
//  wb1_valid     in   1    long-latency writeback request
//  wb1_id        in   5    reg_id_t destination
//  wb1_data      in   32   op_t value
//  wb1_ready     out  1    req1 accepted this cycle
//  mark_valid    in   1    issue of a long-latency op; reserves mark_id
//  mark_id       in   5    reg_id_t destination being reserved
//  mark_ready    out  1    reservation accepted (counter for mark_id not saturated)
//  rs_id, rt_id  in   5    decode source operands to check
//  rs_busy       out  1    rs_id has an outstanding long-latency write
//  rt_busy       out  1    rt_id has an outstanding long-latency write
//  enable_write  out  1    to register file
//  write_id      out  5    to register file
//  write_data    out  32   to register file
// BEHAVIOUR
//  Reset
//   - While rst=1: every output is forced to 0; all counters cleared; starve counter = 0.
//   - Reset mid-transfer drops the transfer with no write.
//  Arbitration (combinational, zero latency)
//   - force1 = (starve == STARVE_LIMIT).
//   - grant1 = wb1_valid & (force1 | ~wb0_valid); grant0 = wb0_valid & ~grant1.
//   - wbN_ready = grantN. A transfer occurs on the cycle valid & ready are both high.
//   - Port mux selects the granted requester's id/data.
//   - enable_write = (grant0 | grant1) & (selected id != 0).
//   - A grant to id 0 still completes the handshake but never writes.
//   - With no grant: write_id = 0, write_data = 0.
//  Starve counter (4 bits)
//   - Cleared when: wb1_valid=0, or req1 is accepted.
//   - Otherwise increments when wb1_valid & ~wb1_ready; saturates at STARVE_LIMIT.
//   - force1 overrides req0 for exactly that cycle; the counter then clears.
//  Scoreboard (32 x CNT_W counters; entry 0 is hard-wired 0)
//   - inc = mark_valid & mark_ready & mark_id != 0.
//   - dec = grant1 & wb1_id != 0.
//   - inc and dec on the same id in the same cycle: net count unchanged.
//   - dec on a zero counter is a protocol error; hold at 0 and fire an assertion.
//   - mark_ready = ~rst & (cnt[mark_id] != MAX | dec on the same id this cycle).
//  Busy
//   - rs_busy = rs_id != 0 & cnt[rs_id] != 0, except when dec hits rs_id this cycle
//     and cnt[rs_id] == 1. In that case the value is bypassed, so busy = 0.
//   - rt_busy is computed the same way from rt_id.
//   - Busy never reflects a mark made in the same cycle; decode issues and marks atomically.
// STRUCTURE
//  - Types: add wb_req_t struct {bit valid; reg_id_t id; op_t data;} and pend_cnt_t (CNT_W bits).
//  - Parameters: STARVE_LIMIT_DEFAULT.
//  - Sub-module wb_scoreboard: the counter bank plus busy/mark_ready logic
//    (inputs inc/dec/ids, outputs busy/ready).
//  - The top level holds the arbiter, the starve counter and the port mux.
// TESTING
//  1. Reset: assert rst mid-grant with wb1_valid=1, id=5.
//     -> all outputs 0 immediately; cnt[5]=0 after release.
//  2. Priority: wb0 (id3, 0xAAAA) and wb1 (id4, 0xBBBB) valid together, wb1 waits under 4.
//     -> req0 writes id3=0xAAAA; wb1_ready=0.
//  3. Starvation: wb0 valid every cycle, wb1 valid with id7.
//     -> wb1 is granted on the 5th cycle with id7; wb0_ready=0 in that cycle only.
//  4. Scoreboard: mark id9 three times.
//     -> mark_ready=0 on the 4th mark; rs_id=9 gives rs_busy=1.
//     -> after three wb1 retires of id9, rs_busy=0 in the cycle of the third retire.
//  5. Simultaneous: mark id9 and wb1 retire id9 in the same cycle with cnt=3.
//     -> mark_ready=1; cnt stays 3; enable_write=1, write_id=9.
//  6. Zero register: wb0 id0 data 0xFFFF, and mark id0.
//     -> wb0_ready=1, enable_write=0; mark_ready=1; cnt[0] and rs_busy(id0) stay 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Register ids, operand data, writeback request bundle and counter widths.
package regfile_wb_arbiter_pkg;

    localparam int NUM_REGS             = 32;
    localparam int REG_ID_W             = 5;
    localparam int OP_W                 = 32;
    localparam int STARVE_W             = 4;
    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int CNT_W_DEFAULT        = 2;

    typedef logic [REG_ID_W-1:0]      reg_id_t;
    typedef logic [OP_W-1:0]          op_t;
    typedef logic [STARVE_W-1:0]      starve_t;
    typedef logic [CNT_W_DEFAULT-1:0] pend_cnt_t;

    typedef struct packed {
        bit      valid;
        reg_id_t id;
        op_t     data;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '0;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register pending long-latency write counters.
// Produces reservation acceptance and decode RAW busy flags.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    mark_valid_i,
    input  reg_id_t mark_id_i,
    output logic    mark_ready_o,
    input  logic    dec_i,
    input  reg_id_t dec_id_i,
    input  reg_id_t rs_id_i,
    input  reg_id_t rt_id_i,
    output logic    rs_busy_o,
    output logic    rt_busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    logic inc;
    logic dec;

    assign dec = dec_i & (dec_id_i != '0);

    // A retire to the same id frees a slot in the same cycle
    assign mark_ready_o = ~rst
                        & ((cnt_q[mark_id_i] != CNT_MAX)
                        | (dec & (dec_id_i == mark_id_i)));

    assign inc = mark_valid_i & mark_ready_o & (mark_id_i != '0);

    function automatic logic src_busy(
        input reg_id_t          id,
        input logic [CNT_W-1:0] cnt,
        input logic             dec_hit
    );
        logic last_retire;
        last_retire = dec_hit & (cnt == CNT_ONE);
        return (id != '0) & (cnt != '0) & ~last_retire;
    endfunction

    assign rs_busy_o = ~rst & src_busy(rs_id_i, cnt_q[rs_id_i],
                                       dec & (dec_id_i == rs_id_i));
    assign rt_busy_o = ~rst & src_busy(rt_id_i, cnt_q[rt_id_i],
                                       dec & (dec_id_i == rt_id_i));

    assign cnt_d[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        logic inc_hit;
        logic dec_hit;
        logic [CNT_W-1:0] cur;

        assign cur     = cnt_q[g];
        assign inc_hit = inc & (mark_id_i == reg_id_t'(g));
        assign dec_hit = dec & (dec_id_i == reg_id_t'(g));

        always_comb begin
            cnt_d[g] = cur;
            if (inc_hit & ~dec_hit) begin
                cnt_d[g] = cur + CNT_ONE;
            end else if (dec_hit & ~inc_hit & (cur != '0)) begin
                cnt_d[g] = cur - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Retiring a register with nothing outstanding means the producer lost track
    dec_underflow: assert property (
        @(posedge clk) disable iff (rst)
        !(dec && (cnt_q[dec_id_i] == '0))
    );

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between pipeline writeback and the
// long-latency unit, with starvation guard and RAW scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wb0_valid,
    input  reg_id_t wb0_id,
    input  op_t     wb0_data,
    output logic    wb0_ready,
    input  logic    wb1_valid,
    input  reg_id_t wb1_id,
    input  op_t     wb1_data,
    output logic    wb1_ready,
    input  logic    mark_valid,
    input  reg_id_t mark_id,
    output logic    mark_ready,
    input  reg_id_t rs_id,
    input  reg_id_t rt_id,
    output logic    rs_busy,
    output logic    rt_busy,
    output logic    enable_write,
    output reg_id_t write_id,
    output op_t     write_data
);

    localparam starve_t LIMIT   = starve_t'(STARVE_LIMIT);
    localparam starve_t STV_ONE = starve_t'(1);

    wb_req_t req0;
    wb_req_t req1;
    wb_req_t sel;

    starve_t starve_q;
    starve_t starve_d;

    logic force1;
    logic grant0;
    logic grant1;

    assign req0 = '{valid: wb0_valid, id: wb0_id, data: wb0_data};
    assign req1 = '{valid: wb1_valid, id: wb1_id, data: wb1_data};

    assign force1 = (starve_q == LIMIT);
    assign grant1 = ~rst & req1.valid & (force1 | ~req0.valid);
    assign grant0 = ~rst & req0.valid & ~grant1;

    assign wb0_ready = grant0;
    assign wb1_ready = grant1;

    always_comb begin
        starve_d = starve_q;
        if (!req1.valid || grant1) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + STV_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        sel = WB_REQ_IDLE;
        unique case (1'b1)
            grant1:  sel = req1;
            grant0:  sel = req0;
            default: sel = WB_REQ_IDLE;
        endcase
    end

    assign enable_write = sel.valid & (sel.id != '0);
    assign write_id     = sel.id;
    assign write_data   = sel.data;

    wb_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .mark_valid_i (mark_valid),
        .mark_id_i    (mark_id),
        .mark_ready_o (mark_ready),
        .dec_i        (grant1),
        .dec_id_i     (wb1_id),
        .rs_id_i      (rs_id),
        .rt_id_i      (rt_id),
        .rs_busy_o    (rs_busy),
        .rt_busy_o    (rt_busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised + directed bench for regfile_wb_arbiter.
// Expected outputs are queued per cycle and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;
    localparam int MAXC  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb0_valid, wb1_valid, mark_valid;
    logic [4:0]  wb0_id, wb1_id, mark_id, rs_id, rt_id;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready, mark_ready;
    logic        rs_busy, rt_busy, enable_write;
    logic [4:0]  write_id;
    logic [31:0] write_data;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_data(wb0_data),
        .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_data(wb1_data),
        .wb1_ready(wb1_ready),
        .mark_valid(mark_valid), .mark_id(mark_id), .mark_ready(mark_ready),
        .rs_id(rs_id), .rt_id(rt_id), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .enable_write(enable_write), .write_id(write_id),
        .write_data(write_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r0, r1, mr, rsb, rtb, en;
        logic [4:0]  wid;
        logic [31:0] wd;
    } exp_t;

    exp_t expq[$];
    int   pend[32];
    int   waited = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("wb0_ready",    32'(wb0_ready),    32'(e.r0));
            check("wb1_ready",    32'(wb1_ready),    32'(e.r1));
            check("mark_ready",   32'(mark_ready),   32'(e.mr));
            check("rs_busy",      32'(rs_busy),      32'(e.rsb));
            check("rt_busy",      32'(rt_busy),      32'(e.rtb));
            check("enable_write", 32'(enable_write), 32'(e.en));
            check("write_id",     32'(write_id),     32'(e.wid));
            check("write_data",   write_data,        e.wd);
        end
    end

    function automatic logic model_busy(input logic [4:0] s, input logic retire,
                                        input logic [4:0] rid);
        if (s == 0 || pend[s] == 0) return 1'b0;
        // the last outstanding write is retiring now: value is bypassed
        if (retire && rid == s && pend[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle(input logic r,
                         input logic w0v, input logic [4:0] w0i, input logic [31:0] w0d,
                         input logic w1v, input logic [4:0] w1i, input logic [31:0] w1d,
                         input logic mv, input logic [4:0] mi,
                         input logic [4:0] s, input logic [4:0] t);
        exp_t e;
        int   win;
        logic retire;
        @(posedge clk);
        #1;
        rst = r;
        wb0_valid = w0v; wb0_id = w0i; wb0_data = w0d;
        wb1_valid = w1v; wb1_id = w1i; wb1_data = w1d;
        mark_valid = mv; mark_id = mi; rs_id = s; rt_id = t;
        e = '0;
        if (r) begin
            foreach (pend[k]) pend[k] = 0;
            waited = 0;
        end else begin
            if (w1v && (waited >= LIMIT || !w0v)) win = 1;
            else if (w0v) win = 0;
            else win = -1;
            e.r0 = (win == 0);
            e.r1 = (win == 1);
            if (win == 0) begin e.wid = w0i; e.wd = w0d; end
            if (win == 1) begin e.wid = w1i; e.wd = w1d; end
            e.en = (win >= 0) && (e.wid != 0);
            retire = (win == 1) && (w1i != 0);
            e.mr  = (pend[mi] < MAXC) || (retire && w1i == mi);
            e.rsb = model_busy(s, retire, w1i);
            e.rtb = model_busy(t, retire, w1i);
            if (retire) pend[w1i]--;
            if (mv && e.mr && mi != 0) pend[mi]++;
            waited = (w1v && win != 1) ? waited + 1 : 0;
        end
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] s, input logic [4:0] t);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, s, t);
    endtask

    initial begin
        int         live[$];
        logic       w0v, w1v, mv, r;
        logic [4:0] w1i;
        rst = 1; wb0_valid = 0; wb1_valid = 0; mark_valid = 0;
        wb0_id = 0; wb1_id = 0; mark_id = 0; rs_id = 0; rt_id = 0;
        wb0_data = 0; wb1_data = 0;
        foreach (pend[k]) pend[k] = 0;

        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_mark_ready", 32'(mark_ready), 0);

        // priority: req0 wins while req1 has not starved
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        cycle(0, 1, 3, 32'hAAAA, 1, 4, 32'hBBBB, 0, 0, 4, 0);
        check("prio_write_id", 32'(write_id), 3);
        check("prio_write_data", write_data, 32'hAAAA);
        check("prio_wb1_ready", 32'(wb1_ready), 0);
        cycle(0, 0, 0, 0, 1, 4, 32'hBBBB, 0, 0, 4, 0);

        // starvation: req1 forced through on the 5th stalled cycle
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 1, 2, $urandom, 1, 7, 32'h7777, 0, 0, 7, 0);
            if (k < 5) check("starve_wb0_ready", 32'(wb0_ready), 1);
        end
        check("starve_wb1_ready", 32'(wb1_ready), 1);
        check("starve_wb0_low", 32'(wb0_ready), 0);
        check("starve_write_id", 32'(write_id), 7);
        idle(0, 0);

        // scoreboard saturation and bypass on last retire
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        check("sat_mark_ready", 32'(mark_ready), 0);
        check("sat_rs_busy", 32'(rs_busy), 1);
        cycle(0, 0, 0, 0, 1, 9, 32'h9999, 1, 9, 9, 9);
        check("simul_mark_ready", 32'(mark_ready), 1);
        check("simul_enable", 32'(enable_write), 1);
        check("simul_write_id", 32'(write_id), 9);
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 0, 1, 9, $urandom, 0, 0, 9, 9);
            check("retire_rs_busy", 32'(rs_busy), (k < 3) ? 1 : 0);
        end

        // register zero never writes nor reserves
        cycle(0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 0);
        check("zero_wb0_ready", 32'(wb0_ready), 1);
        check("zero_enable", 32'(enable_write), 0);
        check("zero_mark_ready", 32'(mark_ready), 1);
        check("zero_rs_busy", 32'(rs_busy), 0);

        // reset during a granted long-latency transfer
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        cycle(1, 0, 0, 0, 1, 5, 32'h5555, 0, 0, 5, 0);
        check("rst_wb1_ready", 32'(wb1_ready), 0);
        check("rst_enable", 32'(enable_write), 0);
        check("rst_rs_busy", 32'(rs_busy), 0);
        idle(5, 5);
        check("rst_cnt5_clear", 32'(rs_busy), 0);

        for (int n = 0; n < 2000; n++) begin
            live.delete();
            for (int k = 1; k < 8; k++) if (pend[k] > 0) live.push_back(k);
            r = ($urandom_range(0, 249) == 0);
            w0v = ($urandom_range(0, 2) != 0);
            if (live.size() > 0 && $urandom_range(0, 2) != 0) begin
                w1v = 1;
                w1i = 5'(live[$urandom_range(0, live.size() - 1)]);
            end else begin
                w1v = ($urandom_range(0, 3) == 0);
                w1i = 0;
            end
            mv = $urandom_range(0, 1) == 1;
            cycle(r, w0v, 5'($urandom), $urandom, w1v, w1i, $urandom,
                  mv, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        n_chk++;
        if (expq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
